// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared FSM encoding, default sizes and width helper for vector_argmax
package vector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 12;
    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_MAX_BEATS = 16;

    // ceil(log2(value)), never below 1 so it can size a port
    function automatic int clog2_w(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/argmax_tree.sv
// rtl/argmax_tree.sv - combinational lane reduction to (max, lane index), lower lane wins ties
module argmax_tree
    import vector_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int LANE_W    = clog2_w(NUM_LANES)
) (
    input  logic [NUM_LANES*WIDTH-1:0] i_lanes,
    input  logic                       i_signed,
    output logic [WIDTH-1:0]           o_max,
    output logic [LANE_W-1:0]          o_idx
);

    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s);
        return s ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    // Heap layout: node n has children 2n (lower lanes) and 2n+1; leaves sit at NUM_LANES+lane.
    genvar n;
    for (n = 1; n < 2 * NUM_LANES; n++) begin : g_node
        logic [WIDTH-1:0]  w_val;
        logic [LANE_W-1:0] w_idx;
        if (n >= NUM_LANES) begin : g_leaf
            assign w_val = i_lanes[(n-NUM_LANES)*WIDTH +: WIDTH];
            assign w_idx = LANE_W'(n - NUM_LANES);
        end else begin : g_join
            logic w_take_hi;
            assign w_take_hi = gt(g_node[2*n+1].w_val, g_node[2*n].w_val, i_signed);
            assign w_val     = w_take_hi ? g_node[2*n+1].w_val : g_node[2*n].w_val;
            assign w_idx     = w_take_hi ? g_node[2*n+1].w_idx : g_node[2*n].w_idx;
        end
    end

    assign o_max = g_node[1].w_val;
    assign o_idx = g_node[1].w_idx;

endmodule

// File: rtl/vector_argmax.sv
// rtl/vector_argmax.sv - multi-beat streaming argmax with start/done control
module vector_argmax
    import vector_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    parameter int BEAT_W    = clog2_w(MAX_BEATS + 1),
    parameter int IDX_W     = clog2_w(NUM_LANES * MAX_BEATS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [BEAT_W-1:0]          num_beats,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*WIDTH-1:0] vec_in,
    output logic [WIDTH-1:0]           max_out,
    output logic [IDX_W-1:0]           idx_out,
    output logic                       done,
    output logic                       busy
);

    localparam int LANE_W = clog2_w(NUM_LANES);

    state_t            r_state;
    state_t            w_next;
    logic              r_signed;
    logic [BEAT_W-1:0] r_count;
    logic [BEAT_W-1:0] r_beat;
    logic              r_first;
    logic [WIDTH-1:0]  r_run_max;
    logic [IDX_W-1:0]  r_run_idx;
    logic [WIDTH-1:0]  r_max_out;
    logic [IDX_W-1:0]  r_idx_out;
    logic              r_done;

    logic [WIDTH-1:0]  w_beat_max;
    logic [LANE_W-1:0] w_lane;
    logic [BEAT_W-1:0] w_eff_count;
    logic [IDX_W-1:0]  w_flat;
    logic              w_accept;
    logic              w_last;
    logic              w_update;

    argmax_tree #(
        .WIDTH     (WIDTH),
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_tree (
        .i_lanes  (vec_in),
        .i_signed (r_signed),
        .o_max    (w_beat_max),
        .o_idx    (w_lane)
    );

    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s);
        return s ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    always_comb begin
        w_eff_count = num_beats;
        if (num_beats == '0) begin
            w_eff_count = BEAT_W'(1);
        end else if (num_beats > BEAT_W'(MAX_BEATS)) begin
            w_eff_count = BEAT_W'(MAX_BEATS);
        end
    end

    // NUM_LANES is a power of two, so beat*NUM_LANES+lane is a plain concatenation
    assign w_flat   = IDX_W'({r_beat, w_lane});
    assign w_accept = in_valid && (r_state == ST_ACCUM);
    assign w_last   = (r_beat == (r_count - BEAT_W'(1)));
    assign w_update = r_first || gt(w_beat_max, r_run_max, r_signed);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_ACCUM;
            ST_ACCUM:  if (w_accept && w_last) w_next = ST_FINISH;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_signed  <= 1'b0;
            r_count   <= '0;
            r_beat    <= '0;
            r_first   <= 1'b0;
            r_run_max <= '0;
            r_run_idx <= '0;
            r_max_out <= '0;
            r_idx_out <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (r_state == ST_IDLE && start) begin
                r_signed <= signed_mode;
                r_count  <= w_eff_count;
                r_beat   <= '0;
                r_first  <= 1'b1;
            end
            if (w_accept) begin
                r_beat  <= r_beat + BEAT_W'(1);
                r_first <= 1'b0;
                if (w_update) begin
                    r_run_max <= w_beat_max;
                    r_run_idx <= w_flat;
                end
            end
            if (r_state == ST_FINISH) begin
                r_max_out <= r_run_max;
                r_idx_out <= r_run_idx;
                r_done    <= 1'b1;
            end
        end
    end

    assign in_ready = (r_state == ST_ACCUM);
    assign busy     = (r_state == ST_ACCUM) || (r_state == ST_FINISH);
    assign max_out  = r_max_out;
    assign idx_out  = r_idx_out;
    assign done     = r_done;

endmodule

// File: tb/tb_vector_argmax.sv
// tb/tb_vector_argmax.sv - directed self-checking bench for vector_argmax
module tb_vector_argmax;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [4:0]  num_beats;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] vec_in;
    logic [11:0] max_out;
    logic [5:0]  idx_out;
    logic        done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [47:0] beats [0:31];

    vector_argmax dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .num_beats   (num_beats),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .vec_in      (vec_in),
        .max_out     (max_out),
        .idx_out     (idx_out),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) acc_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic s, input int nb);
        start       = 1'b1;
        signed_mode = s;
        num_beats   = 5'(nb);
        tick();
        start = 1'b0;
    endtask

    // Streams beats[] continuously until done appears or the cycle budget runs out.
    task automatic run_full(input logic s, input int nb, output logic ok, output int consumed);
        int a0;
        int k;
        a0 = acc_cnt;
        ok = 1'b0;
        start_op(s, nb);
        for (int c = 0; c < 60; c++) begin
            k = acc_cnt - a0;
            if (k > 31) k = 31;
            in_valid = 1'b1;
            vec_in   = beats[k];
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        consumed = acc_cnt - a0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (max_out !== 12'h000) begin n_bad++; $display("FAIL reset_max: got %h want 000", max_out); end
        n_cmp++; if (idx_out !== 6'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", idx_out); end
        n_cmp++; if ({done, busy, in_ready} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl: got %b want 000", {done, busy, in_ready}); end
        reset = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_ready: got %b want 0", in_ready); end
    endtask

    task automatic test_single_beat();
        int d0;
        d0 = done_cnt;
        start_op(1'b0, 1);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL start_ready: got %b want 1", in_ready); end
        in_valid = 1'b1;
        vec_in   = {12'h010, 12'h7FF, 12'h005, 12'h123};
        tick();
        in_valid = 1'b0;
        vec_in   = {4{12'hFFF}};
        n_cmp++; if ({done, busy} !== 2'b01) begin n_bad++; $display("FAIL finish_state: got done,busy=%b want 01", {done, busy}); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if ({done, busy} !== 2'b10) begin n_bad++; $display("FAIL done_pulse: got done,busy=%b want 10", {done, busy}); end
        n_cmp++; if (max_out !== 12'h7FF) begin n_bad++; $display("FAIL single_max: got %h want 7ff", max_out); end
        n_cmp++; if (idx_out !== 6'd2) begin n_bad++; $display("FAIL single_idx: got %0d want 2", idx_out); end
        tick();
        n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL finish_start_dropped: got done,busy=%b want 00", {done, busy}); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_signed_vs_unsigned();
        logic ok;
        int   n;
        beats[0] = {12'h003, 12'h002, 12'h001, 12'h800};
        beats[1] = {12'h000, 12'h000, 12'h000, 12'h7FE};
        beats[2] = {4{12'hFFF}};
        run_full(1'b1, 2, ok, n);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL signed_done_timeout: got %b want 1", ok); end
        n_cmp++; if (max_out !== 12'h7FE) begin n_bad++; $display("FAIL signed_max: got %h want 7fe", max_out); end
        n_cmp++; if (idx_out !== 6'd4) begin n_bad++; $display("FAIL signed_idx: got %0d want 4", idx_out); end
        tick();
        run_full(1'b0, 2, ok, n);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL unsigned_done_timeout: got %b want 1", ok); end
        n_cmp++; if (max_out !== 12'h800) begin n_bad++; $display("FAIL unsigned_max: got %h want 800", max_out); end
        n_cmp++; if (idx_out !== 6'd0) begin n_bad++; $display("FAIL unsigned_idx: got %0d want 0", idx_out); end
        tick();
    endtask

    task automatic test_ties();
        logic ok;
        int   n;
        for (int i = 0; i < 4; i++) beats[i] = {4{12'h055}};
        run_full(1'b0, 3, ok, n);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tie_done_timeout: got %b want 1", ok); end
        n_cmp++; if (idx_out !== 6'd0) begin n_bad++; $display("FAIL tie_all_idx: got %0d want 0", idx_out); end
        n_cmp++; if (max_out !== 12'h055) begin n_bad++; $display("FAIL tie_all_max: got %h want 055", max_out); end
        tick();
        beats[1] = {12'h055, 12'h055, 12'h0AA, 12'h055};
        beats[2] = {12'h055, 12'h055, 12'h0AA, 12'h055};
        run_full(1'b1, 3, ok, n);
        n_cmp++; if (idx_out !== 6'd5) begin n_bad++; $display("FAIL tie_pair_idx: got %0d want 5", idx_out); end
        n_cmp++; if (max_out !== 12'h0AA) begin n_bad++; $display("FAIL tie_pair_max: got %h want 0aa", max_out); end
        tick();
    endtask

    task automatic test_gaps();
        logic [6:0]  pat;
        logic [47:0] gb [0:3];
        int a0, d0, b;
        logic ok;
        pat   = 7'b1011001;
        gb[0] = {12'h004, 12'h003, 12'h002, 12'h001};
        gb[1] = {12'h040, 12'h030, 12'h020, 12'h010};
        gb[2] = {12'h321, 12'h100, 12'h100, 12'h100};
        gb[3] = {4{12'h200}};
        a0 = acc_cnt;
        d0 = done_cnt;
        b  = 0;
        start_op(1'b0, 4);
        for (int c = 0; c < 7; c++) begin
            in_valid    = pat[c];
            vec_in      = pat[c] ? gb[b] : {4{12'hFFF}};
            start       = (c == 2);
            num_beats   = 5'd1;
            signed_mode = 1'b1;
            tick();
            if (pat[c]) b++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        vec_in   = {4{12'hFFF}};
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL gap_done_timeout: got %b want 1", ok); end
        n_cmp++; if (acc_cnt - a0 !== 4) begin n_bad++; $display("FAIL gap_beats: got %0d want 4", acc_cnt - a0); end
        n_cmp++; if (max_out !== 12'h321) begin n_bad++; $display("FAIL gap_max: got %h want 321", max_out); end
        n_cmp++; if (idx_out !== 6'd11) begin n_bad++; $display("FAIL gap_idx: got %0d want 11", idx_out); end
        repeat (4) tick();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL gap_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_bounds();
        logic ok;
        int   n;
        beats[0] = {12'h001, 12'h002, 12'h009, 12'h003};
        for (int i = 1; i < 32; i++) beats[i] = {4{12'hFFF}};
        run_full(1'b0, 0, ok, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL zero_beats_consumed: got %0d want 1", n); end
        n_cmp++; if ({max_out, idx_out} !== {12'h009, 6'd1}) begin n_bad++; $display("FAIL zero_beats_result: got %h/%0d want 009/1", max_out, idx_out); end
        tick();
        for (int i = 0; i < 16; i++) beats[i] = {4{12'(i)}};
        beats[15] = {12'hFFE, 12'h001, 12'h001, 12'h001};
        run_full(1'b0, 19, ok, n);
        n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL clamp_consumed: got %0d want 16", n); end
        n_cmp++; if (max_out !== 12'hFFE) begin n_bad++; $display("FAIL clamp_max: got %h want ffe", max_out); end
        n_cmp++; if (idx_out !== 6'd63) begin n_bad++; $display("FAIL last_lane_idx: got %0d want 63", idx_out); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int   d0;
        logic ok;
        int   n;
        d0 = done_cnt;
        start_op(1'b0, 4);
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            vec_in   = {4{12'h0F0}};
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if ({done, busy, in_ready} !== 3'b000) begin n_bad++; $display("FAIL abort_ctl: got %b want 000", {done, busy, in_ready}); end
        n_cmp++; if ({max_out, idx_out} !== 18'd0) begin n_bad++; $display("FAIL abort_outputs: got %h/%0d want 000/0", max_out, idx_out); end
        repeat (3) tick();
        n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, d0); end
        beats[0] = {12'h010, 12'h020, 12'h030, 12'h040};
        beats[1] = {12'h011, 12'h555, 12'h031, 12'h041};
        beats[2] = {12'h012, 12'h022, 12'h032, 12'h042};
        beats[3] = {12'h013, 12'h023, 12'h033, 12'h043};
        run_full(1'b0, 4, ok, n);
        n_cmp++; if ({ok, 5'(n)} !== {1'b1, 5'd4}) begin n_bad++; $display("FAIL after_abort_run: got done=%b beats=%0d want 1/4", ok, n); end
        n_cmp++; if ({max_out, idx_out} !== {12'h555, 6'd6}) begin n_bad++; $display("FAIL after_abort_result: got %h/%0d want 555/6", max_out, idx_out); end
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        num_beats   = 5'd0;
        in_valid    = 1'b0;
        vec_in      = '0;
        for (int i = 0; i < 32; i++) beats[i] = '0;
        test_reset();
        test_single_beat();
        test_signed_vs_unsigned();
        test_ties();
        test_gaps();
        test_bounds();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
